operand_entry_ctrl: RTL and testbench
=====================================

OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: key_valid  input  1  keypad event present.
REQ-004 SHALL have port: key_code  input  4  0-9 digit, 0xA add, 0xB sub, 0xC mul, 0xD div, 0xE clear, 0xF enter.
REQ-005 SHALL have port: key_ready  output  1  key accepted when key_valid && key_ready.
REQ-006 SHALL have port: out_valid  output  1  operand pair and opcode ready for the ALU.
REQ-007 SHALL have port: out_ready  input  1  ALU accepts the pair when out_valid && out_ready.
REQ-008 SHALL have port: opa  output  16  operand A; Q4.6 value in [9:0], [15:10] zero.
REQ-009 SHALL have port: opb  output  16  operand B; same format as opa.
REQ-010 SHALL have port: op_code  output  2  00 add, 01 sub, 10 mul, 11 div.
REQ-011 SHALL have port: entry_pos  output  4  one-hot cursor: [0] unit, [1] tenth, [2] hundredth, [3] operator; 0 in CONV/ISSUE.

Function
REQ-012 SHALL implement the FSM A_UNIT, A_TENTH, A_HUND, A_CONV, OP_SEL, B_UNIT, B_TENTH, B_HUND, B_CONV, ISSUE.
REQ-013 SHALL drive key_ready=1 in all states except A_CONV, B_CONV and ISSUE.
REQ-014 In a digit state, an accepted digit SHALL load the matching digit register and advance: UNIT->TENTH->HUND->CONV.
REQ-015 In a digit state, enter SHALL go directly to that operand's CONV state; unentered digit registers remain 0.
REQ-016 In a digit state, operator keys SHALL be consumed and ignored (no state or data change).
REQ-017 In OP_SEL, an operator key SHALL load op_code and go to B_UNIT; digits and enter SHALL be consumed and ignored.
REQ-018 Clear in any key-accepting state SHALL zero digit registers, opa, opb, op_code and go to A_UNIT.
REQ-019 A_CONV/B_CONV SHALL last exactly one cycle, latch the converter output into opa/opb, zero the digit registers, and go to OP_SEL/ISSUE respectively.
REQ-020 Conversion SHALL be value = {6'b0, unit[3:0], floor((10*tenth + hundredth)*64/100)[5:0]}.
REQ-021 ISSUE SHALL assert out_valid with opa/opb/op_code stable until out_valid && out_ready.
REQ-022 On the handshake cycle, the block SHALL go to A_UNIT next cycle with out_valid=0 and opa/opb retained until overwritten.
REQ-023 Latency: out_valid SHALL rise exactly one cycle after the key completing operand B is accepted.
REQ-024 key_valid while key_ready=0 SHALL have no effect; the keypad source holds the key.
REQ-025 Digit codes are 0-9 only; the converter SHALL never see values above 9.

Reset
REQ-026 On rst, the block SHALL enter A_UNIT with opa=0, opb=0, op_code=00, out_valid=0, key_ready=1, entry_pos=0001 and digit registers 0.
REQ-027 rst SHALL override any key or handshake in the same cycle, including mid-entry and during ISSUE.

Structure
REQ-028 A shared package SHALL hold the state enum, key_code constants, op_code constants and FRAC_BITS=6.
REQ-029 The block SHALL instantiate exactly one decimal_to_binary sub-module, shared by both operands and fed from the digit registers.

Verification
REQ-030 Keys 1,2,5 / add / 3,5,0 -> opa=0x0050, opb=0x00E0, op_code=00, out_valid one cycle after final 0.
REQ-031 Keys 9,9,9 / mul / 7,enter -> opa=0x027F, opb=0x01C0, op_code=10.
REQ-032 out_ready held low 5 cycles in ISSUE -> out_valid and outputs stable, key_ready=0; release -> A_UNIT next cycle.
REQ-033 Keys 4, add, clear -> A_UNIT, op_code=00, opa=0; then enter, sub, enter -> opa=0, opb=0, op_code=01.
REQ-034 Key 6, then key 2 in OP_SEL, then rst mid-B entry -> digit in OP_SEL ignored; post-reset state matches REQ-026.
REQ-035 key_valid held during A_CONV -> key accepted only in OP_SEL on the following cycle.

Source files
------------

// File: rtl/operand_entry_ctrl_pkg.sv
// Shared definitions for the keypad operand entry controller: FSM state
// encoding, keypad codes, ALU opcodes and the fixed-point format.
package operand_entry_ctrl_pkg;

  localparam int FRAC_BITS = 6;
  localparam int DIGIT_W   = 4;
  localparam int OPERAND_W = 16;

  typedef enum logic [3:0] {
    A_UNIT  = 4'd0,
    A_TENTH = 4'd1,
    A_HUND  = 4'd2,
    A_CONV  = 4'd3,
    OP_SEL  = 4'd4,
    B_UNIT  = 4'd5,
    B_TENTH = 4'd6,
    B_HUND  = 4'd7,
    B_CONV  = 4'd8,
    ISSUE   = 4'd9
  } state_t;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic is_operator(input logic [3:0] key);
    return (key >= KEY_ADD) && (key <= KEY_DIV);
  endfunction

  // Operator keys are contiguous from KEY_ADD, so the offset is the opcode.
  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    logic [3:0] offset;
    offset = key - KEY_ADD;
    return offset[1:0];
  endfunction

endpackage

// File: rtl/operand_entry_ctrl_d2b.sv
// decimal_to_binary: converts a three-digit decimal d.dd into unsigned
// fixed point with FRAC_BITS fraction bits; the fraction is truncated.
// Ports: unit/tenth/hund - BCD digits (0-9); value - {zeros, unit, frac}.
module decimal_to_binary
  import operand_entry_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0]   unit,
  input  logic [DIGIT_W-1:0]   tenth,
  input  logic [DIGIT_W-1:0]   hund,
  output logic [OPERAND_W-1:0] value
);

  // 99 * 64 = 6336 fits in 13 bits.
  logic [12:0]          hundredths;
  logic [12:0]          scaled;
  logic [FRAC_BITS-1:0] frac;

  always_comb begin
    hundredths = 13'(tenth) * 13'd10 + 13'(hund);
    scaled     = hundredths << FRAC_BITS;
    frac       = FRAC_BITS'(scaled / 13'd100);
    value      = {{(OPERAND_W - DIGIT_W - FRAC_BITS){1'b0}}, unit, frac};
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: collects two decimal operands (d.dd) and an operator
// from a keypad, converts each to Q4.6 and presents the pair to an ALU.
// Ports: clk, rst (sync, active-high); key_valid/key_code/key_ready keypad
// handshake; out_valid/out_ready ALU handshake; opa, opb, op_code results;
// entry_pos one-hot cursor for the display.
//
// state   | meaning
// A_UNIT  | waiting for operand A units digit
// A_TENTH | waiting for operand A tenths digit
// A_HUND  | waiting for operand A hundredths digit
// A_CONV  | one cycle: latch converted A, clear digits
// OP_SEL  | waiting for an operator key
// B_UNIT  | waiting for operand B units digit
// B_TENTH | waiting for operand B tenths digit
// B_HUND  | waiting for operand B hundredths digit
// B_CONV  | one cycle: latch converted B, clear digits
// ISSUE   | holding out_valid until the ALU takes the pair
module operand_entry_ctrl
  import operand_entry_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic                 key_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPERAND_W-1:0] opa,
  output logic [OPERAND_W-1:0] opb,
  output logic [1:0]           op_code,
  output logic [3:0]           entry_pos
);

  state_t state, state_next;

  logic [DIGIT_W-1:0]   unit_d, tenth_d, hund_d;
  logic [OPERAND_W-1:0] conv_value;
  logic                 accept;

  assign accept = key_valid && key_ready;

  decimal_to_binary u_d2b (
    .unit  (unit_d),
    .tenth (tenth_d),
    .hund  (hund_d),
    .value (conv_value)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= A_UNIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      A_UNIT, A_TENTH, A_HUND: begin
        if (accept) begin
          if (key_code == KEY_CLEAR)      state_next = A_UNIT;
          else if (key_code == KEY_ENTER) state_next = A_CONV;
          else if (is_digit(key_code)) begin
            if (state == A_UNIT)       state_next = A_TENTH;
            else if (state == A_TENTH) state_next = A_HUND;
            else                       state_next = A_CONV;
          end
        end
      end
      A_CONV: state_next = OP_SEL;
      OP_SEL: begin
        if (accept) begin
          if (key_code == KEY_CLEAR)        state_next = A_UNIT;
          else if (is_operator(key_code))   state_next = B_UNIT;
        end
      end
      B_UNIT, B_TENTH, B_HUND: begin
        if (accept) begin
          if (key_code == KEY_CLEAR)      state_next = A_UNIT;
          else if (key_code == KEY_ENTER) state_next = B_CONV;
          else if (is_digit(key_code)) begin
            if (state == B_UNIT)       state_next = B_TENTH;
            else if (state == B_TENTH) state_next = B_HUND;
            else                       state_next = B_CONV;
          end
        end
      end
      B_CONV: state_next = ISSUE;
      ISSUE:  if (out_ready) state_next = A_UNIT;
      default: state_next = A_UNIT;
    endcase
  end

  always_comb begin
    key_ready = 1'b0;
    out_valid = 1'b0;
    entry_pos = 4'b0000;
    case (state)
      A_UNIT, B_UNIT:   begin key_ready = 1'b1; entry_pos = 4'b0001; end
      A_TENTH, B_TENTH: begin key_ready = 1'b1; entry_pos = 4'b0010; end
      A_HUND, B_HUND:   begin key_ready = 1'b1; entry_pos = 4'b0100; end
      OP_SEL:           begin key_ready = 1'b1; entry_pos = 4'b1000; end
      ISSUE:            out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Digits only ever load from codes 0-9, so the converter input
  // stays in range without clamping.
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_d  <= '0;
      tenth_d <= '0;
      hund_d  <= '0;
      opa     <= '0;
      opb     <= '0;
      op_code <= OP_ADD;
    end else if (accept && key_code == KEY_CLEAR) begin
      unit_d  <= '0;
      tenth_d <= '0;
      hund_d  <= '0;
      opa     <= '0;
      opb     <= '0;
      op_code <= OP_ADD;
    end else begin
      case (state)
        A_UNIT, B_UNIT:   if (accept && is_digit(key_code)) unit_d  <= key_code;
        A_TENTH, B_TENTH: if (accept && is_digit(key_code)) tenth_d <= key_code;
        A_HUND, B_HUND:   if (accept && is_digit(key_code)) hund_d  <= key_code;
        OP_SEL:           if (accept && is_operator(key_code)) op_code <= key_to_op(key_code);
        A_CONV: begin
          opa     <= conv_value;
          unit_d  <= '0;
          tenth_d <= '0;
          hund_d  <= '0;
        end
        B_CONV: begin
          opb     <= conv_value;
          unit_d  <= '0;
          tenth_d <= '0;
          hund_d  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
module tb_operand_entry_ctrl;
  import operand_entry_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] opa, opb;
  logic [1:0]  op_code;
  logic [3:0]  entry_pos;

  int n_checks = 0;
  int n_fail   = 0;

  operand_entry_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opa       (opa),
    .opb       (opb),
    .op_code   (op_code),
    .entry_pos (entry_pos)
  );

  always #5 clk = ~clk;

  // Present a key, wait (bounded) until it is accepted, then release it.
  // Returns at 1 time unit after the accepting edge.
  task automatic press(input logic [3:0] code);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      key_code  = code;
      key_valid = 1'b1;
      if (key_ready === 1'b1) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL press_timeout key=%h key_ready=%b required 1", code, key_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    key_valid = 1'b0;
  endtask

  task automatic handshake;
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL handshake_wait out_valid=%b required 1", out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || entry_pos !== 4'b0001 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake valid/pos/ready=%b/%b/%b required 0/0001/1",
               out_valid, entry_pos, key_ready);
    end
  endtask

  task automatic check_issue(input string name, input logic [15:0] ea,
                             input logic [15:0] eb, input logic [1:0] eop);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_conv_cycle out_valid=%b required 0", name, out_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, key_ready, entry_pos, opa, opb, op_code} !== {1'b1, 1'b0, 4'b0000, ea, eb, eop}) begin
      n_fail++;
      $display("FAIL %s_issue valid=%b ready=%b pos=%b opa=%h opb=%h op=%b required 1 0 0000 %h %h %b",
               name, out_valid, key_ready, entry_pos, opa, opb, op_code, ea, eb, eop);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_valid = 1'b1;
    key_code = 4'h5;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({opa, opb, op_code, out_valid, key_ready, entry_pos} !== {16'h0, 16'h0, 2'b00, 1'b0, 1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_state opa=%h opb=%h op=%b valid=%b ready=%b pos=%b required 0 0 00 0 1 0001",
               opa, opb, op_code, out_valid, key_ready, entry_pos);
    end
    rst = 1'b0;
    key_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_fraction_entry;
    press(4'd1);
    n_checks++;
    if (entry_pos !== 4'b0010) begin
      n_fail++;
      $display("FAIL cursor_tenth pos=%b required 0010", entry_pos);
    end
    press(4'd2);
    press(4'd5);
    n_checks++;
    if (entry_pos !== 4'b0000 || key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a_conv pos=%b ready=%b required 0000 0", entry_pos, key_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (entry_pos !== 4'b1000 || opa !== 16'h0050) begin
      n_fail++;
      $display("FAIL op_sel_opa pos=%b opa=%h required 1000 0050", entry_pos, opa);
    end
    press(KEY_ADD);
    press(4'd3);
    press(4'd5);
    press(4'd0);
    check_issue("add125_350", 16'h0050, 16'h00E0, OP_ADD);
    handshake();
  endtask

  task automatic test_enter_short;
    press(4'd9);
    press(4'd9);
    press(4'd9);
    press(KEY_MUL);
    press(4'd7);
    press(KEY_ENTER);
    check_issue("mul999_7", 16'h027F, 16'h01C0, OP_MUL);
    handshake();
  endtask

  task automatic test_issue_stall;
    press(4'd2);
    press(KEY_ENTER);
    press(KEY_DIV);
    press(4'd1);
    press(KEY_ENTER);
    check_issue("div2_1", 16'h0080, 16'h0040, OP_DIV);
    key_valid = 1'b1;
    key_code = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, key_ready, opa, opb, op_code} !== {1'b1, 1'b0, 16'h0080, 16'h0040, OP_DIV}) begin
        n_fail++;
        $display("FAIL stall_%0d valid=%b ready=%b opa=%h opb=%h op=%b required 1 0 0080 0040 11",
                 i, out_valid, key_ready, opa, opb, op_code);
      end
    end
    key_valid = 1'b0;
    handshake();
    n_checks++;
    if (opa !== 16'h0080 || opb !== 16'h0040) begin
      n_fail++;
      $display("FAIL retained opa=%h opb=%h required 0080 0040", opa, opb);
    end
  endtask

  task automatic test_clear;
    press(4'd4);
    press(KEY_ADD);
    n_checks++;
    if (entry_pos !== 4'b0010) begin
      n_fail++;
      $display("FAIL op_in_digit pos=%b required 0010", entry_pos);
    end
    press(KEY_CLEAR);
    n_checks++;
    if ({entry_pos, op_code, opa, opb} !== {4'b0001, 2'b00, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL clear pos=%b op=%b opa=%h opb=%h required 0001 00 0 0",
               entry_pos, op_code, opa, opb);
    end
    press(KEY_ENTER);
    press(KEY_SUB);
    press(KEY_ENTER);
    check_issue("enter_sub_enter", 16'h0000, 16'h0000, OP_SUB);
    handshake();
  endtask

  task automatic test_reset_mid_entry;
    press(4'd6);
    press(KEY_ENTER);
    press(4'd2);
    n_checks++;
    if (entry_pos !== 4'b1000 || op_code !== OP_SUB || opa !== 16'h0180) begin
      n_fail++;
      $display("FAIL digit_in_op_sel pos=%b op=%b opa=%h required 1000 01 0180",
               entry_pos, op_code, opa);
    end
    press(KEY_DIV);
    press(4'd3);
    @(negedge clk);
    rst = 1'b1;
    key_valid = 1'b1;
    key_code = 4'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_valid = 1'b0;
    n_checks++;
    if ({opa, opb, op_code, out_valid, key_ready, entry_pos} !== {16'h0, 16'h0, 2'b00, 1'b0, 1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_mid_b opa=%h opb=%h op=%b valid=%b ready=%b pos=%b required 0 0 00 0 1 0001",
               opa, opb, op_code, out_valid, key_ready, entry_pos);
    end
    press(4'd1);
    press(KEY_ENTER);
    press(KEY_SUB);
    press(KEY_ENTER);
    check_issue("pre_reset_issue", 16'h0040, 16'h0000, OP_SUB);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, entry_pos, opa, op_code} !== {1'b0, 4'b0001, 16'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_in_issue valid=%b pos=%b opa=%h op=%b required 0 0001 0 00",
               out_valid, entry_pos, opa, op_code);
    end
  endtask

  task automatic test_hold_during_conv;
    press(4'd8);
    press(KEY_ENTER);
    key_valid = 1'b1;
    key_code = KEY_MUL;
    @(negedge clk);
    n_checks++;
    if (key_ready !== 1'b0 || entry_pos !== 4'b0000) begin
      n_fail++;
      $display("FAIL hold_a_conv ready=%b pos=%b required 0 0000", key_ready, entry_pos);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (key_ready !== 1'b1 || entry_pos !== 4'b1000 || opa !== 16'h0200 || op_code !== OP_ADD) begin
      n_fail++;
      $display("FAIL hold_op_sel ready=%b pos=%b opa=%h op=%b required 1 1000 0200 00",
               key_ready, entry_pos, opa, op_code);
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    n_checks++;
    if (entry_pos !== 4'b0001 || op_code !== OP_MUL) begin
      n_fail++;
      $display("FAIL hold_accepted pos=%b op=%b required 0001 10", entry_pos, op_code);
    end
    press(KEY_ENTER);
    check_issue("hold", 16'h0200, 16'h0000, OP_MUL);
    handshake();
  endtask

  initial begin
    test_reset();
    test_fraction_entry();
    test_enter_short();
    test_issue_stall();
    test_clear();
    test_reset_mid_entry();
    test_hold_during_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
